mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  clock; all state updates on rising edge.
REQ-002 SHALL have: rst  in  1  asynchronous, active-low reset (0 = reset).
REQ-003 SHALL have: rdy  in  1  global enable; 0 freezes all state.
REQ-004 SHALL have: mem_din  in  8  RAM read byte; data for the address driven in cycle t appears in cycle t+1.
REQ-005 SHALL have: mem_dout  out  8  RAM write byte; mem_a  out  32  RAM byte address; mem_wr  out  1  write strobe (1 = write).
REQ-006 SHALL have: io_buffer_full  in  1  I/O sink cannot accept a write.
REQ-007 SHALL have: if_req  in  1; if_addr  in  32; if_row  out  512; if_done  out  1  (instruction-fetch line-fill port).
REQ-008 SHALL have: ls_req  in  1; ls_we  in  1; ls_addr  in  32; ls_size  in  2 (0=1B, 1=2B, 2=4B); ls_wdata  in  32; ls_rdata  out  32; ls_done  out  1  (load/store port).
REQ-009 SHALL have: rollback  in  1  pipeline flush.

Function
REQ-010 SHALL implement FSM states IDLE, IF_READ, LS_READ, LS_WRITE, plus a 7-bit byte counter cnt and a 1-bit round-robin pointer rr.
REQ-011 Each requester SHALL hold req and its fields stable until its done pulse; done SHALL be a registered one-cycle pulse.
REQ-012 In IDLE with exactly one req high and no done output high that cycle: grant at the next edge, latch fields, clear cnt.
REQ-013 With both requests high in IDLE: grant IF if rr=0, else LS; rr SHALL toggle to the non-granted requester after every grant.
REQ-014 No grant SHALL occur in a cycle where if_done or ls_done is high.
REQ-015 IF_READ: base = {if_addr[31:6], 6'b0}; cycle k after grant (k=0..63) drives mem_a = base+k, mem_wr=0; byte k is captured from mem_din at the end of cycle k+1 into if_row[8k+7:8k].
REQ-016 if_done SHALL be high in cycle 65 after grant, with if_row complete and held until the next IF grant; the state returns to IDLE during that same cycle.
REQ-017 LS_READ, n = 1/2/4 bytes: drive mem_a = ls_addr+k for k=0..n-1; byte k goes to ls_rdata[8k+7:8k] and upper bytes are zero; ls_done SHALL be high in cycle n+1.
REQ-018 LS_WRITE: in cycle k drive mem_wr=1, mem_a = ls_addr+k, mem_dout = ls_wdata[8k+7:8k]; ls_done SHALL be high in cycle n.
REQ-019 I/O stall: if ls_addr[17:16]=2'b11 and io_buffer_full=1, a write cycle SHALL drive mem_wr=0 and not advance cnt; it resumes when io_buffer_full drops.
REQ-020 rollback during LS_READ SHALL abort: IDLE next edge, no ls_done issued.
REQ-021 rollback SHALL NOT affect IF_READ or LS_WRITE (stores are committed; the fetch unit still expects its line).
REQ-022 rdy=0: mem_wr forced 0; FSM, cnt, rr and captured data held; the operation resumes and the byte in flight is re-issued (the address is re-driven before capture).
REQ-023 Whenever no access is active (IDLE, or an IF/LS-read cycle with no address to issue): mem_wr=0 and mem_dout=0. In IDLE, mem_a=0.
REQ-024 Address arithmetic SHALL be 32-bit and wrap modulo 2^32.
REQ-025 ls_size=3 SHALL be treated as 4 bytes.

Reset
REQ-026 rst=0 SHALL immediately force IDLE, cnt=0, rr=0, and mem_wr, mem_a, mem_dout, if_done, ls_done, if_row, ls_rdata all to 0, regardless of clk or rdy.
REQ-027 Reset mid-operation SHALL discard the partial transfer with no done pulse.
REQ-028 After rst returns to 1, the first grant SHALL follow REQ-012/013.

Verification
REQ-029 IF fill: if_addr=0x1234, RAM[i]=i&0xFF -> if_done in cycle 65, if_row[7:0]=0x00 (address 0x1200), if_row[511:504]=0x3F.
REQ-030 Simultaneous: if_req=ls_req=1 after reset -> IF granted first (rr=0); LS granted in the cycle after if_done, with no grant while if_done is high.
REQ-031 Store word: ls_addr=0x100, ls_wdata=0xAABBCCDD, ls_size=2 -> mem_wr=1 for cycles 0..3 with bytes DD,CC,BB,AA at 0x100..0x103; ls_done in cycle 4.
REQ-032 I/O stall: byte store to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr=0 for those 3 cycles, then one write; ls_done one cycle after the write.
REQ-033 Rollback: half-word load with rollback in cycle 1 -> no ls_done, IDLE next cycle; pending if_req granted next.
REQ-034 Reset/rdy: rst=0 at IF cycle 30 -> all outputs 0 at once, no if_done. rdy=0 for 5 cycles during a load -> same ls_rdata as an unstalled run, ls_done delayed 5 cycles.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates a 64-byte instruction line-fill port and a 1/2/4-byte
// load/store port onto a single byte-wide RAM with one-cycle read latency.
// Both requesters hold their request fields until their registered done pulse.
module mem_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic [7:0]   mem_din,
  output logic [7:0]   mem_dout,
  output logic [31:0]  mem_a,
  output logic         mem_wr,
  input  logic         io_buffer_full,
  input  logic         if_req,
  input  logic [31:0]  if_addr,
  output logic [511:0] if_row,
  output logic         if_done,
  input  logic         ls_req,
  input  logic         ls_we,
  input  logic [31:0]  ls_addr,
  input  logic [1:0]   ls_size,
  input  logic [31:0]  ls_wdata,
  output logic [31:0]  ls_rdata,
  output logic         ls_done,
  input  logic         rollback
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_IF_READ,
    ST_LS_READ,
    ST_LS_WRITE
  } state_e;

  localparam logic [6:0] IF_LAST_CNT = 7'd64;  // cycle that captures byte 63

  state_e       state_q,    state_d;
  logic [6:0]   cnt_q,      cnt_d;
  logic         rr_q,       rr_d;        // 0: fetch has priority on a tie
  logic [31:0]  addr_q,     addr_d;      // line base or load/store start address
  logic [2:0]   len_q,      len_d;       // load/store byte count (1, 2 or 4)
  logic [31:0]  wdata_q,    wdata_d;
  logic [511:0] if_row_q,   if_row_d;
  logic [31:0]  ls_rdata_q, ls_rdata_d;
  logic         if_done_q,  if_done_d;
  logic         ls_done_q,  ls_done_d;

  logic         grant_if;
  logic         grant_ls;
  logic         io_stall;
  logic [6:0]   prev_idx;                // byte whose read data is on mem_din now
  logic [6:0]   addr_off;

  // Size code 3 is treated the same as a word access.
  function automatic logic [2:0] size_to_len(input logic [1:0] size);
    case (size)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  assign io_stall = io_buffer_full && (addr_q[17:16] == 2'b11);
  assign prev_idx = cnt_q - 7'd1;

  // Next-state, counter and captured-data logic; nothing moves while rdy is low.
  always_comb begin
    // NOTE: every signal assigned here gets its default first, so no path leaves one unassigned and no latch is inferred.
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_d       = rr_q;
    addr_d     = addr_q;
    len_d      = len_q;
    wdata_d    = wdata_q;
    if_row_d   = if_row_q;
    ls_rdata_d = ls_rdata_q;
    if_done_d  = 1'b0;
    ls_done_d  = 1'b0;
    grant_if   = 1'b0;
    grant_ls   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A done pulse still on the outputs means that requester has not yet
        // seen it and may still be holding req, so no grant this cycle.
        if (rdy && !if_done_q && !ls_done_q) begin
          grant_if = if_req && (!ls_req || !rr_q);
          grant_ls = ls_req && !grant_if;
          if (grant_if) begin
            state_d = ST_IF_READ;
            addr_d  = if_addr & 32'hFFFF_FFC0;
            cnt_d   = 7'd0;
            rr_d    = 1'b1;
          end else if (grant_ls) begin
            state_d = ls_we ? ST_LS_WRITE : ST_LS_READ;
            addr_d  = ls_addr;
            len_d   = size_to_len(ls_size);
            wdata_d = ls_wdata;
            cnt_d   = 7'd0;
            rr_d    = 1'b0;
            if (!ls_we) ls_rdata_d = 32'd0;
          end
        end
      end

      ST_IF_READ: begin
        if (rdy) begin
          cnt_d = cnt_q + 7'd1;
          if (cnt_q != 7'd0) if_row_d[{prev_idx[5:0], 3'b000} +: 8] = mem_din;
          if (cnt_q == IF_LAST_CNT) begin
            state_d   = ST_IDLE;
            if_done_d = 1'b1;
          end
        end
      end

      ST_LS_READ: begin
        if (rdy) begin
          if (rollback) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 7'd1;
            if (cnt_q != 7'd0) ls_rdata_d[{prev_idx[1:0], 3'b000} +: 8] = mem_din;
            if (cnt_q == {4'd0, len_q}) begin
              state_d   = ST_IDLE;
              ls_done_d = 1'b1;
            end
          end
        end
      end

      ST_LS_WRITE: begin
        if (rdy && !io_stall) begin
          cnt_d = cnt_q + 7'd1;
          if (cnt_q + 7'd1 == {4'd0, len_q}) begin
            state_d   = ST_IDLE;
            ls_done_d = 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // RAM-side outputs, decoded from the current state and counter.
  always_comb begin
    mem_wr   = 1'b0;
    mem_dout = 8'd0;
    mem_a    = 32'd0;
    addr_off = cnt_q;

    case (state_q)
      ST_IF_READ, ST_LS_READ: begin
        // While stalled, keep presenting the address of the byte not yet
        // captured so mem_din holds that byte when the stall ends.
        if (!rdy && (cnt_q != 7'd0)) addr_off = prev_idx;
        mem_a = addr_q + {25'd0, addr_off};
      end
      ST_LS_WRITE: begin
        mem_a = addr_q + {25'd0, cnt_q};
        if (rdy && !io_stall) begin
          mem_wr   = 1'b1;
          mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        end
      end
      default: ;
    endcase
  end

  // State register; reset clears everything, including the returned data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 7'd0;
      rr_q       <= 1'b0;
      addr_q     <= 32'd0;
      len_q      <= 3'd0;
      wdata_q    <= 32'd0;
      // NOTE: the wide line buffer is reset on purpose: outputs must read zero during reset.
      if_row_q   <= 512'd0;
      ls_rdata_q <= 32'd0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_q       <= rr_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      wdata_q    <= wdata_d;
      if_row_q   <= if_row_d;
      ls_rdata_q <= ls_rdata_d;
      if_done_q  <= if_done_d;
      ls_done_q  <= ls_done_d;
    end
  end

  assign if_row   = if_row_q;
  assign if_done  = if_done_q;
  assign ls_rdata = ls_rdata_q;
  assign ls_done  = ls_done_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: scoreboard bench for mem_ctrl. Drivers push expected line
// fills, load data and store bytes; a negedge monitor pops and compares.
module tb_mem_ctrl;

  typedef enum int {OP_IF, OP_RD, OP_WR} op_e;
  typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;
  typedef struct { bit is_read; logic [31:0] data; } ls_t;

  logic         clk = 1'b0;
  logic         rst, rdy;
  logic [7:0]   mem_din, mem_dout;
  logic [31:0]  mem_a;
  logic         mem_wr, io_buffer_full;
  logic         if_req, if_done;
  logic [31:0]  if_addr;
  logic [511:0] if_row;
  logic         ls_req, ls_we, ls_done, rollback;
  logic [31:0]  ls_addr, ls_wdata, ls_rdata;
  logic [1:0]   ls_size;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [7:0]   env_mem [logic [31:0]];  // RAM contents as written by the DUT
  logic [7:0]   ref_mem [logic [31:0]];  // RAM contents the bench expects
  logic [511:0] if_q [$];
  ls_t          ls_q [$];
  wr_t          wr_q [$];
  wr_t          mon_w;
  ls_t          mon_l;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .if_req(if_req), .if_addr(if_addr), .if_row(if_row), .if_done(if_done),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_size(ls_size),
    .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_done(ls_done),
    .rollback(rollback)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Unwritten RAM locations hold the low byte of their address.
  function automatic logic [7:0] env_rd(input logic [31:0] a);
    return env_mem.exists(a) ? env_mem[a] : a[7:0];
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : a[7:0];
  endfunction

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  // RAM: one-cycle read latency, writes take effect at the edge.
  always @(posedge clk) begin
    if (mem_wr) env_mem[mem_a] = mem_dout;
    mem_din <= env_rd(mem_a);
  end

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every store byte and every done pulse with the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      if (mem_wr) begin
        check("wr_while_stalled", (!rdy) || (io_buffer_full && ls_addr[17:16] == 2'b11), 0);
        if (wr_q.size() == 0) check("wr_unexpected", 1, 0);
        else begin
          mon_w = wr_q.pop_front();
          check("wr_addr", mem_a, mon_w.a);
          check("wr_data", mem_dout, mon_w.d);
        end
      end
      if (if_done) begin
        if (if_q.size() == 0) check("if_done_unexpected", 1, 0);
        else check("if_row", if_row, if_q.pop_front());
      end
      if (ls_done) begin
        if (ls_q.size() == 0) check("ls_done_unexpected", 1, 0);
        else begin
          mon_l = ls_q.pop_front();
          if (mon_l.is_read) check("ls_rdata", ls_rdata, mon_l.data);
        end
      end
    end
  end

  // Reference model: what each operation must return or write.
  task automatic push_expect(input op_e kind, input logic [31:0] addr,
                             input logic [1:0] size, input logic [31:0] wdata);
    logic [511:0] row;
    logic [31:0]  base, data;
    int n;
    n = nbytes(size);
    case (kind)
      OP_IF: begin
        base = addr & 32'hFFFF_FFC0;
        row  = '0;
        for (int i = 0; i < 64; i++) row[8*i +: 8] = ref_rd(base + 32'(i));
        if_q.push_back(row);
      end
      OP_RD: begin
        data = 32'd0;
        for (int k = 0; k < n; k++) data[8*k +: 8] = ref_rd(addr + 32'(k));
        ls_q.push_back('{1'b1, data});
      end
      default: begin
        for (int k = 0; k < n; k++) begin
          wr_q.push_back('{addr + 32'(k), wdata[8*k +: 8]});
          ref_mem[addr + 32'(k)] = wdata[8*k +: 8];
        end
        ls_q.push_back('{1'b0, 32'd0});
      end
    endcase
  endtask

  // Issue one operation, apply rdy/io stalls (scheduled or random) and check
  // that done arrives exactly base latency + stall cycles after the grant.
  task automatic run_op(input op_e kind, input logic [31:0] addr, input logic [1:0] size,
                        input logic [31:0] wdata, input int stall_at, input int stall_len,
                        input int io_at, input int io_len, input bit rnd);
    int c, n, lat, stalls;
    bit got, done_now;
    push_expect(kind, addr, size, wdata);
    @(posedge clk); #1;
    rdy = 1'b1; io_buffer_full = 1'b0;
    if (kind == OP_IF) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      ls_req = 1'b1; ls_we = (kind == OP_WR); ls_addr = addr; ls_size = size; ls_wdata = wdata;
    end
    c = cyc; n = nbytes(size); stalls = 0; got = 1'b0;
    lat = (kind == OP_IF) ? 65 : (kind == OP_RD) ? n + 1 : n;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      done_now = (kind == OP_IF) ? if_done : ls_done;
      if (done_now) begin
        got = 1'b1;
        check("done_latency", cyc - c - 1, lat + stalls);
        break;
      end
      if (rnd) begin
        rdy = ($urandom_range(0, 3) != 0);
        io_buffer_full = ($urandom_range(0, 2) == 0);
      end else begin
        rdy = !(k >= stall_at && k < stall_at + stall_len);
        io_buffer_full = (k >= io_at && k < io_at + io_len);
      end
      if (!rdy || (kind == OP_WR && io_buffer_full && addr[17:16] == 2'b11)) stalls++;
    end
    if (!got) check("done_timeout", 0, 1);
    rdy = 1'b1; io_buffer_full = 1'b0; if_req = 1'b0; ls_req = 1'b0;
  endtask

  // Both requests together: fetch first (rr=0), load only after if_done.
  task automatic sim_test(input logic [31:0] fa, input logic [31:0] la);
    int c;
    bit got;
    push_expect(OP_IF, fa, 2'd0, 32'd0);
    push_expect(OP_RD, la, 2'd1, 32'd0);
    @(posedge clk); #1;
    rdy = 1'b1; if_req = 1'b1; if_addr = fa;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = la; ls_size = 2'd1;
    c = cyc; got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (if_done) begin got = 1'b1; break; end
    end
    check("sim_if_done_cycle", got ? cyc - c : 0, 66);
    check("sim_no_grant_in_done", mem_a, 32'd0);
    if_req = 1'b0;
    @(posedge clk); #1;
    check("sim_idle_after_done", mem_a, 32'd0);
    @(posedge clk); #1;
    check("sim_ls_granted", mem_a, la);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (ls_done) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("sim_ls_done_cycle", got ? cyc - c : 0, 71);
    ls_req = 1'b0;
  endtask

  // Half-word load flushed in its cycle 1, with a fetch waiting behind it.
  task automatic rollback_test();
    int c;
    bit got;
    @(posedge clk); #1;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h400; ls_size = 2'd1;
    c = cyc;
    @(posedge clk); #1;
    check("rb_cycle0_addr", mem_a, 32'h400);
    push_expect(OP_IF, 32'h0000_0655, 2'd0, 32'd0);
    if_req = 1'b1; if_addr = 32'h0000_0655;
    @(posedge clk); #1;
    check("rb_cycle1_addr", mem_a, 32'h401);
    rollback = 1'b1; ls_req = 1'b0;
    @(posedge clk); #1;
    rollback = 1'b0;
    check("rb_idle_addr", mem_a, 32'd0);
    check("rb_no_ls_done", ls_done, 1'b0);
    @(posedge clk); #1;
    check("rb_if_granted", mem_a, 32'h0000_0640);
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (if_done) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("rb_if_done_cycle", got ? cyc - c : 0, 69);
    if_req = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_mem_a"}, mem_a, 32'd0);
    check({tag, "_mem_wr"}, mem_wr, 1'b0);
    check({tag, "_mem_dout"}, mem_dout, 8'd0);
    check({tag, "_if_done"}, if_done, 1'b0);
    check({tag, "_ls_done"}, ls_done, 1'b0);
    check({tag, "_if_row"}, if_row, 512'd0);
    check({tag, "_ls_rdata"}, ls_rdata, 32'd0);
  endtask

  // Reset asserted between edges in fetch cycle 30: outputs clear at once.
  task automatic reset_mid_if();
    @(posedge clk); #1;
    rdy = 1'b1; if_req = 1'b1; if_addr = 32'h0000_2000;
    repeat (31) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_outputs_zero("midrst");
    if_req = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    repeat (80) @(posedge clk);
  endtask

  initial begin
    logic [31:0] unstalled, a;
    op_e kind;
    rst = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0; rollback = 1'b0;
    if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0;
    ls_addr = '0; ls_size = '0; ls_wdata = '0;
    #12;
    check_outputs_zero("reset");
    #11 rst = 1'b1;

    sim_test(32'h0000_8000, 32'h50);

    run_op(OP_IF, 32'h0000_1234, 2'd0, 32'd0, -1, 0, -1, 0, 1'b0);
    check("fill_byte0", if_row[7:0], 8'h00);
    check("fill_byte63", if_row[511:504], 8'h3F);

    run_op(OP_WR, 32'h100, 2'd2, 32'hAABB_CCDD, -1, 0, -1, 0, 1'b0);
    run_op(OP_RD, 32'h100, 2'd2, 32'd0, -1, 0, -1, 0, 1'b0);
    check("load_back_word", ls_rdata, 32'hAABB_CCDD);

    run_op(OP_WR, 32'h0003_0000, 2'd0, 32'h0000_005A, -1, 0, 0, 3, 1'b0);
    run_op(OP_RD, 32'h0003_0000, 2'd0, 32'd0, -1, 0, -1, 0, 1'b0);
    check("io_byte_readback", ls_rdata, 32'h0000_005A);

    run_op(OP_RD, 32'h0000_0200, 2'd2, 32'd0, -1, 0, -1, 0, 1'b0);
    unstalled = ls_rdata;
    run_op(OP_RD, 32'h0000_0200, 2'd2, 32'd0, 2, 5, -1, 0, 1'b0);
    check("stalled_load_same_data", ls_rdata, unstalled);

    rollback_test();

    run_op(OP_WR, 32'hFFFF_FFFE, 2'd3, 32'h1122_3344, -1, 0, -1, 0, 1'b0);
    run_op(OP_RD, 32'hFFFF_FFFE, 2'd2, 32'd0, -1, 0, -1, 0, 1'b0);
    check("wrap_word", ls_rdata, 32'h1122_3344);

    reset_mid_if();
    sim_test(32'h0001_0080, 32'h0000_0102);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0:       kind = OP_IF;
        1:       kind = OP_RD;
        default: kind = OP_WR;
      endcase
      case ($urandom_range(0, 3))
        0:       a = $urandom & 32'h0000_FFFF;
        1:       a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        2:       a = 32'h0003_0000 | ($urandom & 32'h0000_00FF);
        default: a = $urandom;
      endcase
      run_op(kind, a, 2'($urandom_range(0, 3)), $urandom, -1, 0, -1, 0, 1'b1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (4) @(posedge clk);
    check("if_queue_drained", if_q.size(), 0);
    check("ls_queue_drained", ls_q.size(), 0);
    check("wr_queue_drained", wr_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
